// File: rtl/multimem_wide_if.sv
// Bus bundle for multimem_wide: narrow write port, wide read port, busy status.
interface multimem_wide_if #(
  parameter int WR_WIDTH      = 8,
  parameter int WR_ADDR_BITS  = 12,
  parameter int RD_RATIO_LOG2 = 1
);
  localparam int RD_WIDTH     = WR_WIDTH << RD_RATIO_LOG2;
  localparam int RD_ADDR_BITS = WR_ADDR_BITS - RD_RATIO_LOG2;

  logic                    wr_en;
  logic [WR_ADDR_BITS-1:0] wr_addr;
  logic [WR_WIDTH-1:0]     wr_data;
  logic                    rd_en;
  logic [RD_ADDR_BITS-1:0] rd_addr;
  logic [RD_WIDTH-1:0]     rd_data;
  logic                    rd_valid;
  logic                    busy;

  // Writer / reader side (command writer, row scanner)
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  // Memory side
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/multimem_wide.sv
// Asymmetric simple dual-port frame memory: narrow write words, wide read
// words holding 2^RD_RATIO_LOG2 write words (lane k = write address with
// low bits k). After reset the whole array is zeroed, one read row per cycle,
// while busy is high. Read is registered with one cycle latency.
// Optional macro MULTIMEM_WIDE_WRITE_BYPASS_EN: on a same-row read/write
// collision the written lane is forwarded (write-first); otherwise read-first.
module multimem_wide #(
  parameter int WR_WIDTH      = 8,
  parameter int WR_ADDR_BITS  = 12,
  parameter int RD_RATIO_LOG2 = 1
) (
  input  logic           clk,
  input  logic           reset,   // asynchronous, active low
  multimem_wide_if.slave bus
);
  localparam int RD_RATIO     = 1 << RD_RATIO_LOG2;
  localparam int RD_WIDTH     = WR_WIDTH << RD_RATIO_LOG2;
  localparam int RD_ADDR_BITS = WR_ADDR_BITS - RD_RATIO_LOG2;
  localparam int RD_DEPTH     = 1 << RD_ADDR_BITS;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state_reg, state_next;
  logic [RD_ADDR_BITS-1:0] clear_ptr_reg, clear_ptr_next;
  logic                    clearing;
  logic                    wr_fire, rd_fire;
  logic                    rd_valid_reg;
  logic [RD_ADDR_BITS-1:0] wr_row;
  logic [RD_RATIO-1:0]     wr_lane_sel;   // one-hot lane of the write
  logic [RD_WIDTH-1:0]     rd_word;

  assign clearing = (state_reg == ST_CLEAR);
  assign wr_fire  = bus.wr_en && !clearing;
  assign rd_fire  = bus.rd_en && !clearing;

  // Split the write address into row and lane
  if (RD_RATIO_LOG2 > 0) begin : g_split
    assign wr_row      = bus.wr_addr[WR_ADDR_BITS-1:RD_RATIO_LOG2];
    assign wr_lane_sel = RD_RATIO'(1) << bus.wr_addr[RD_RATIO_LOG2-1:0];
  end else begin : g_nosplit
    assign wr_row      = bus.wr_addr;
    assign wr_lane_sel = '1;
  end

  // State register and clear pointer; reset restarts the clear from row 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_CLEAR;
      clear_ptr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_ptr_reg <= clear_ptr_next;
    end
  end

  // Next state: sweep every row once, then stay idle until the next reset
  always_comb begin
    state_next     = state_reg;
    clear_ptr_next = clear_ptr_reg;
    case (state_reg)
      ST_CLEAR: begin
        clear_ptr_next = clear_ptr_reg + 1'b1;
        if (clear_ptr_reg == RD_ADDR_BITS'(RD_DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read strobe: one valid per accepted read request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
    end
  end

  // One narrow RAM per lane so each lane has its own write enable
  for (genvar gi = 0; gi < RD_RATIO; gi++) begin : g_lane
    logic [WR_WIDTH-1:0]     mem [RD_DEPTH];
    logic                    lane_we;
    logic [RD_ADDR_BITS-1:0] lane_addr;
    logic [WR_WIDTH-1:0]     lane_wdata;
    logic [WR_WIDTH-1:0]     rd_lane_reg;

    // Write port mux: the clear sweep owns the RAM while busy
    always_comb begin
      lane_we    = 1'b0;
      lane_addr  = wr_row;
      lane_wdata = bus.wr_data;
      if (clearing) begin
        lane_we    = 1'b1;
        lane_addr  = clear_ptr_reg;
        lane_wdata = '0;
      end else begin
        lane_we = wr_fire && wr_lane_sel[gi];
      end
    end

    // RAM write; contents are not reset
    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem[lane_addr] <= lane_wdata;
      end
    end

    // Registered read; holds its value between reads
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_lane_reg <= '0;
      end else if (rd_fire) begin
`ifdef MULTIMEM_WIDE_WRITE_BYPASS_EN
        if (wr_fire && wr_lane_sel[gi] && (wr_row == bus.rd_addr)) begin
          rd_lane_reg <= bus.wr_data;
        end else begin
          rd_lane_reg <= mem[bus.rd_addr];
        end
`else
        rd_lane_reg <= mem[bus.rd_addr];
`endif
      end
    end

    assign rd_word[gi*WR_WIDTH +: WR_WIDTH] = rd_lane_reg;
  end

  assign bus.rd_data  = rd_word;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.busy     = clearing;
endmodule

// File: doc/multimem_wide.md
Name: multimem_wide

Overview:
- Parametrised successor to the fixed 8-bit-write / 16-bit-read display frame memory.
- Single-clock, asymmetric-width simple dual-port RAM: narrow write port, wide read port packing RD_RATIO write words per read word.
- Adds a post-reset clear sequencer, registered read with a valid strobe, and defined read-during-write collision behaviour.
- Sits between the UART/command writer and the panel row scanner.

Parameters:
- WR_WIDTH, 8, bits per write word.
- WR_ADDR_BITS, 12, write address width; total write words = 2^WR_ADDR_BITS.
- RD_RATIO_LOG2, 1, read word = 2^RD_RATIO_LOG2 write words.
- Derived RD_WIDTH = WR_WIDTH << RD_RATIO_LOG2.
- Derived RD_ADDR_BITS = WR_ADDR_BITS - RD_RATIO_LOG2.
- Derived RD_DEPTH = 2^RD_ADDR_BITS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- wr_en  in  1  write strobe.
- wr_addr  in  WR_ADDR_BITS  write word address.
- wr_data  in  WR_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  RD_ADDR_BITS  read word address.
- rd_data  out  RD_WIDTH  read data.
- rd_valid  out  1  rd_data valid this cycle.
- busy  out  1  clear sequence in progress.

Behaviour:
- Lane mapping:
  - lane = wr_addr[RD_RATIO_LOG2-1:0]; row = wr_addr[WR_ADDR_BITS-1:RD_RATIO_LOG2].
  - Lane k occupies rd_data[k*WR_WIDTH +: WR_WIDTH].
  - Defaults: write 0xFFE="B", 0xFFF="A" -> read 0x7FF = 0x4142.
- Reset asserted:
  - Outputs: rd_data=0, rd_valid=0, busy=1.
  - FSM forced to CLEAR; clear_ptr=0.
  - Memory contents are not reset asynchronously.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes an all-zero RD_WIDTH word at clear_ptr and increments it. After writing RD_DEPTH-1, go to IDLE; busy falls the same edge. Clear takes exactly RD_DEPTH cycles after reset deassertion (2048 at defaults).
  - IDLE: normal operation; stays until the next reset.
- During CLEAR:
  - wr_en is ignored (data dropped).
  - rd_en is ignored; rd_valid stays 0 and rd_data holds 0.
- Write (IDLE, wr_en=1): updates only the addressed lane of the row at the clock edge. Other lanes are untouched. No backpressure.
- Read (IDLE, rd_en=1):
  - 1-cycle latency: rd_data and rd_valid=1 appear the edge after the request.
  - rd_valid is high for exactly one cycle per rd_en cycle; back-to-back reads give back-to-back valids.
  - rd_data holds its last value when rd_valid=0.
- Collision (rd_en and wr_en same cycle, same row): read-first by default. The returned word is pre-write content and the write still lands. Different rows: independent.
- Reset mid-CLEAR or mid-read: the async clear wins immediately; the pending rd_valid is dropped and the clear restarts from 0.
- Address wrap: none; all addresses are in range by construction.

Optional Feature:
- Macro: MULTIMEM_WIDE_WRITE_BYPASS_EN.
- Defined: on a same-row collision, the written lane is forwarded into rd_data (write-first). Other lanes show stored content. Adds a bypass mux on the output register; latency is unchanged.
- Undefined: read-first, as above; no bypass logic is synthesised.

Test Plan:
- Reset low 3 cycles then high -> busy=1 for exactly 2048 cycles; a read of 0x000 and 0x7FF then returns 0x0000.
- Write 0xFFF="A", then 0xFFE="B"; read 0x7FF -> next cycle rd_valid=1, rd_data=0x4142; rd_valid low the following cycle.
- Overwrite 0xFFF="C"; read 0x7FF -> 0x4342 (lane 0 "B" preserved).
- Same cycle: write 0xFFE="E" and read 0x7FF after row holds 0x4342:
  - Without bypass macro -> 0x4342; a following read returns 0x4345.
  - With bypass macro -> 0x4345.
- wr_en 0x7FF="Z" during CLEAR -> ignored; read 0x3FF after clear -> 0x0000. Writes 0x7FF="Z", 0x7FE="Y" after clear, then read 0x3FF -> 0x5A59.
- Reset pulsed low mid-clear (cycle 1000) with rd_en high -> rd_valid=0, busy=1 immediately; a full 2048-cycle clear follows.
